// File: rtl/mips_pkg.sv
// Shared fetch-path types: FSM states, jump encodings and reset PC default.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [1:0]  JUMP_NONE        = 2'b00;
  localparam logic [1:0]  JUMP_J           = 2'b01;
  localparam logic [1:0]  JUMP_JR          = 2'b10;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection for an accepted instruction.
// Priority: jr, j, taken branch, sequential; all arithmetic wraps modulo 2^32.
module next_pc_logic
  import mips_pkg::*;
(
  input  logic [31:0] instr_pc,
  input  logic [25:0] instr_idx,
  input  logic        pc_src,
  input  logic [1:0]  jump,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        jr_misaligned
);

  logic [31:0] pc4;
  logic [31:0] br_off;

  assign pc4    = instr_pc + 32'd4;
  assign br_off = {{14{instr_idx[15]}}, instr_idx[15:0], 2'b00};

  always_comb begin
    next_pc       = pc4;
    jr_misaligned = 1'b0;
    // Reserved jump encoding falls through to the branch/sequential path.
    if (jump == JUMP_JR) begin
      next_pc       = jr_target;
      jr_misaligned = (jr_target[1:0] != 2'b00);
    end else if (jump == JUMP_J) begin
      next_pc = {pc4[31:28], instr_idx, 2'b00};
    end else if (pc_src) begin
      next_pc = pc4 + br_off;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch FSM: IDLE -> FETCH -> HOLD -> FETCH ..., HALT on misaligned jr.
// Holds PC, presented instruction and retired counter; next PC comes from next_pc_logic.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pc_src,
  input  logic [1:0]  jump,
  input  logic [31:0] jr_target,
  output logic        fault,
  output logic [31:0] retired
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  retired_q, retired_d;
  logic [31:0]  next_pc;
  logic         jr_misaligned;
  logic         accept;

  next_pc_logic u_next_pc (
    .instr_pc      (instr_pc_q),
    .instr_idx     (instr_q[25:0]),
    .pc_src        (pc_src),
    .jump          (jump),
    .jr_target     (jr_target),
    .next_pc       (next_pc),
    .jr_misaligned (jr_misaligned)
  );

  assign accept = (state_q == ST_HOLD) && instr_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    fault_d    = fault_q;
    retired_d  = retired_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          retired_d = retired_q + 32'd1;
          if (jr_misaligned) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      fault_q    <= 1'b0;
      retired_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      fault_q    <= fault_d;
      retired_q  <= retired_d;
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ST_HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fault       = fault_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, branch/jump/jr redirects, stalls, fault halt and resets.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_src;
  logic [1:0]  jump;
  logic [31:0] jr_target;
  logic        fault;
  logic [31:0] retired;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_retired = 32'd0;
  int cyc = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_src      (pc_src),
    .jump        (jump),
    .jr_target   (jr_target),
    .fault       (fault),
    .retired     (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) @(negedge clk);
    check_eq("req_seen", {31'd0, imem_req}, 32'd1);
  endtask

  // Fetch one word at exp_addr with 'delay' cycles of ack latency; leaves the DUT in HOLD.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int delay);
    wait_req();
    check_eq("fetch_addr", imem_addr, exp_addr);
    for (int i = 0; i < delay; i++) begin
      imem_ack = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check_eq("stall_addr", imem_addr, exp_addr);
      check_eq("stall_req", {31'd0, imem_req}, 32'd1);
      check_eq("stall_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    check_eq("hold_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("hold_instr", instr, word);
    check_eq("hold_pc", instr_pc, exp_addr);
  endtask

  // Stall 'stall' cycles with a hazardous control pattern, then accept with the given controls.
  task automatic accept(input int stall, input logic psrc, input logic [1:0] jmp,
                        input logic [31:0] jrt, input logic [31:0] exp_instr, input logic [31:0] exp_pc);
    for (int i = 0; i < stall; i++) begin
      instr_ready = 1'b0;
      pc_src = 1'b1;
      jump = 2'b10;
      jr_target = 32'h0000_0003;
      @(negedge clk);
      check_eq("ready_stall_valid", {31'd0, instr_valid}, 32'd1);
      check_eq("ready_stall_instr", instr, exp_instr);
      check_eq("ready_stall_pc", instr_pc, exp_pc);
      check_eq("ready_stall_retired", retired, exp_retired);
    end
    instr_ready = 1'b1;
    pc_src = psrc;
    jump = jmp;
    jr_target = jrt;
    @(negedge clk);
    instr_ready = 1'b0;
    pc_src = 1'b0;
    jump = 2'b00;
    jr_target = 32'h0;
    exp_retired = exp_retired + 32'd1;
    check_eq("retired", retired, exp_retired);
  endtask

  initial begin
    int c0;
    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    instr_ready = 1'b0;
    pc_src = 1'b0;
    jump = 2'b00;
    jr_target = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_instr", instr, 32'd0);
    check_eq("rst_instr_pc", instr_pc, 32'd0);
    check_eq("rst_fault", {31'd0, fault}, 32'd0);
    check_eq("rst_retired", retired, 32'd0);
    check_eq("rst_addr", imem_addr, 32'd0);

    rst_n = 1'b1;
    check_eq("idle_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);

    // Sequential run at full rate: three instructions in six cycles.
    c0 = cyc;
    fetch(32'h0, 32'h0000_0000, 0); accept(0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    fetch(32'h4, 32'h0000_0001, 0); accept(0, 1'b0, 2'b00, 32'h0, 32'h1, 32'h4);
    fetch(32'h8, 32'h0000_0002, 0); accept(0, 1'b0, 2'b00, 32'h0, 32'h2, 32'h8);
    check_eq("throughput_cycles", cyc - c0, 32'd6);
    check_eq("retired_3", retired, 32'd3);

    // Branches at 0x40: forward +3 words and backward -1 word.
    fetch(32'hC, 32'h0, 0);            accept(0, 1'b0, 2'b10, 32'h40, 32'h0, 32'hC);
    fetch(32'h40, 32'h1000_0003, 0);   accept(0, 1'b1, 2'b00, 32'h0, 32'h1000_0003, 32'h40);
    fetch(32'h50, 32'h0, 0);           accept(0, 1'b0, 2'b10, 32'h40, 32'h0, 32'h50);
    fetch(32'h40, 32'h1000_FFFF, 0);   accept(0, 1'b1, 2'b00, 32'h0, 32'h1000_FFFF, 32'h40);
    fetch(32'h40, 32'h0, 0);           accept(0, 1'b0, 2'b10, 32'h4000_0000, 32'h0, 32'h40);

    // j keeps pc4[31:28]; then delayed ack and ready stall with jr beating pc_src.
    fetch(32'h4000_0000, 32'h0800_0010, 0);
    accept(0, 1'b0, 2'b01, 32'h0, 32'h0800_0010, 32'h4000_0000);
    fetch(32'h4000_0040, 32'h1000_0005, 3);
    accept(2, 1'b1, 2'b10, 32'h0000_0200, 32'h1000_0005, 32'h4000_0040);

    // Wrap at top of address space, then reserved jump encoding acts as none.
    fetch(32'h200, 32'h0, 0);          accept(0, 1'b0, 2'b10, 32'hFFFF_FFFC, 32'h0, 32'h200);
    fetch(32'hFFFF_FFFC, 32'h0, 0);    accept(0, 1'b0, 2'b00, 32'h0, 32'h0, 32'hFFFF_FFFC);
    fetch(32'h0, 32'h0800_0100, 0);    accept(0, 1'b0, 2'b11, 32'h0, 32'h0800_0100, 32'h0);
    fetch(32'h4, 32'h1000_0003, 0);    accept(0, 1'b1, 2'b11, 32'h0, 32'h1000_0003, 32'h4);

    // Misaligned jr: halt with fault, PC frozen, stray acks ignored.
    fetch(32'h14, 32'h0, 0);           accept(0, 1'b0, 2'b10, 32'h0000_0202, 32'h0, 32'h14);
    check_eq("halt_fault", {31'd0, fault}, 32'd1);
    check_eq("halt_req", {31'd0, imem_req}, 32'd0);
    check_eq("halt_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("halt_addr", imem_addr, 32'h14);
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    instr_ready = 1'b1;
    repeat (4) @(negedge clk);
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    check_eq("halt_fault_sticky", {31'd0, fault}, 32'd1);
    check_eq("halt_req_held", {31'd0, imem_req}, 32'd0);
    check_eq("halt_valid_held", {31'd0, instr_valid}, 32'd0);
    check_eq("halt_retired_held", retired, exp_retired);

    // Reset out of HALT, then reset asynchronously while holding PC 0x8.
    #2 rst_n = 1'b0;
    #1 check_eq("halt_rst_fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_retired = 32'd0;
    @(negedge clk);
    fetch(32'h0, 32'hA, 0); accept(0, 1'b0, 2'b00, 32'h0, 32'hA, 32'h0);
    fetch(32'h4, 32'hB, 0); accept(0, 1'b0, 2'b00, 32'h0, 32'hB, 32'h4);
    fetch(32'h8, 32'hC, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("async_rst_retired", retired, 32'd0);
    check_eq("async_rst_instr", instr, 32'd0);
    check_eq("async_rst_addr", imem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_retired = 32'd0;
    imem_ack = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_ack = 1'b0;
    check_eq("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    fetch(32'h0, 32'h5555_0000, 0);
    accept(0, 1'b0, 2'b00, 32'h0, 32'h5555_0000, 32'h0);
    wait_req();
    check_eq("post_rst_next_addr", imem_addr, 32'h4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
